// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types, state encodings and the priority pick for mem_arbiter
package mem_arbiter_pkg;
   localparam int ADDR_W_DEF    = 32;
   localparam int WORD_W_DEF    = 32;
   localparam int ROB_IDX_W_DEF = 4;
   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;
   typedef logic [ADDR_W_DEF-1:0]    addr_tp;
   typedef logic [WORD_W_DEF-1:0]    word_tp;
   typedef logic [ROB_IDX_W_DEF-1:0] rob_idx_tp;
   typedef enum logic [2:0] {ARB_IDLE, ARB_FC, ARB_LD, ARB_ST, ARB_COOL} arb_state_e;
   // store > load > fetch, except a starved fetch jumps the queue
   function automatic arb_state_e arb_pick(input logic st, input logic ld, input logic fc, input logic starved);
      return (fc && starved) ? ARB_FC : st ? ARB_ST : ld ? ARB_LD : fc ? ARB_FC : ARB_IDLE;
   endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch/load/store requests onto a one-hot memctrl channel
// Ports: clk/rst (async, active-high), rdy freezes everything, rb rolls back loads;
// fc_*/st_*/ld_* requester side with *_done pulses; mc_* memctrl side (valid, latched
// payload, done inputs, registered rollback mc_rb).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int WORD_W     = 32,
   parameter int ROB_IDX_W  = 4,
   parameter int STARVE_LIM = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 rb,
   input  logic                 fc_req,
   input  logic [ADDR_W-1:0]    fc_addr,
   output logic                 fc_done,
   input  logic                 st_req,
   input  logic [ADDR_W-1:0]    st_addr,
   input  logic [WORD_W-1:0]    st_data,
   input  logic [3:0]           st_len,
   output logic                 st_done,
   input  logic                 ld_req,
   input  logic [ADDR_W-1:0]    ld_addr,
   input  logic [3:0]           ld_len,
   input  logic                 ld_sext,
   input  logic [ROB_IDX_W-1:0] ld_src,
   output logic                 ld_done,
   output logic                 mc_fc_valid,
   output logic                 mc_st_valid,
   output logic                 mc_ld_valid,
   output logic [ADDR_W-1:0]    mc_addr,
   output logic [WORD_W-1:0]    mc_st_data,
   output logic [3:0]           mc_len,
   output logic                 mc_ld_sext,
   output logic [ROB_IDX_W-1:0] mc_ld_src,
   input  logic                 mc_fc_done,
   input  logic                 mc_st_done,
   input  logic                 mc_ld_done,
   output logic                 mc_rb
);
   localparam int CNT_W = $clog2(STARVE_LIM + 1);
   localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

   arb_state_e state_q, state_d, grant;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic [3:0] len_q, len_d;
   logic sext_q, sext_d;
   logic [ROB_IDX_W-1:0] src_q, src_d;
   logic fc_done_q, fc_done_d, st_done_q, st_done_d, ld_done_q, ld_done_d, rb_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         starve_q  <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         len_q     <= '0;
         sext_q    <= 1'b0;
         src_q     <= '0;
         fc_done_q <= 1'b0;
         st_done_q <= 1'b0;
         ld_done_q <= 1'b0;
         rb_q      <= 1'b0;
      end else if (rdy) begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         len_q     <= len_d;
         sext_q    <= sext_d;
         src_q     <= src_d;
         fc_done_q <= fc_done_d;
         st_done_q <= st_done_d;
         ld_done_q <= ld_done_d;
         rb_q      <= rb;
      end
   end

   always_comb begin
      grant     = arb_pick(st_req, ld_req && !rb, fc_req, starve_q == LIM);
      state_d   = state_q;
      starve_d  = starve_q;
      addr_d    = addr_q;
      data_d    = data_q;
      len_d     = len_q;
      sext_d    = sext_q;
      src_d     = src_q;
      fc_done_d = 1'b0;
      st_done_d = 1'b0;
      ld_done_d = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            state_d = grant;
            if (grant == ARB_FC) begin
               addr_d   = fc_addr;
               starve_d = '0;
            end
            if (grant == ARB_ST) begin
               addr_d = st_addr;
               data_d = st_data;
               len_d  = st_len;
            end
            if (grant == ARB_LD) begin
               addr_d = ld_addr;
               len_d  = ld_len;
               sext_d = ld_sext;
               src_d  = ld_src;
            end
            if ((grant == ARB_ST || grant == ARB_LD) && starve_q != LIM) starve_d = starve_q + CNT_W'(1);
         end
         ARB_FC: begin
            state_d   = mc_fc_done ? ARB_COOL : ARB_FC;
            fc_done_d = mc_fc_done;
         end
         ARB_ST: begin
            state_d   = mc_st_done ? ARB_COOL : ARB_ST;
            st_done_d = mc_st_done;
         end
         // rollback beats a same-cycle completion: the load result is discarded
         ARB_LD: begin
            state_d   = (rb || mc_ld_done) ? ARB_COOL : ARB_LD;
            ld_done_d = mc_ld_done && !rb;
         end
         default: state_d = ARB_IDLE;
      endcase
      if (!fc_req) starve_d = '0;
   end

   always_comb begin
      mc_fc_valid = state_q == ARB_FC;
      mc_st_valid = state_q == ARB_ST;
      mc_ld_valid = state_q == ARB_LD;
      mc_addr     = addr_q;
      mc_st_data  = data_q;
      mc_len      = len_q;
      mc_ld_sext  = sext_q;
      mc_ld_src   = src_q;
      fc_done     = fc_done_q;
      st_done     = st_done_q;
      ld_done     = ld_done_q;
      mc_rb       = rb_q;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (STARVE_LIM=2)
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;
   logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, rb = 1'b0;
   logic fc_req = 1'b0, st_req = 1'b0, ld_req = 1'b0, ld_sext = 1'b0;
   logic [31:0] fc_addr = '0, st_addr = '0, st_data = '0, ld_addr = '0;
   logic [3:0] st_len = '0, ld_len = '0, ld_src = '0;
   logic mc_fc_done = 1'b0, mc_st_done = 1'b0, mc_ld_done = 1'b0;
   logic fc_done, st_done, ld_done, mc_fc_valid, mc_st_valid, mc_ld_valid, mc_ld_sext, mc_rb;
   logic [31:0] mc_addr, mc_st_data;
   logic [3:0] mc_len, mc_ld_src;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .WORD_W(32), .ROB_IDX_W(4), .STARVE_LIM(2)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rb(rb),
      .fc_req(fc_req), .fc_addr(fc_addr), .fc_done(fc_done),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_len(st_len), .st_done(st_done),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_sext(ld_sext), .ld_src(ld_src), .ld_done(ld_done),
      .mc_fc_valid(mc_fc_valid), .mc_st_valid(mc_st_valid), .mc_ld_valid(mc_ld_valid),
      .mc_addr(mc_addr), .mc_st_data(mc_st_data), .mc_len(mc_len), .mc_ld_sext(mc_ld_sext), .mc_ld_src(mc_ld_src),
      .mc_fc_done(mc_fc_done), .mc_st_done(mc_st_done), .mc_ld_done(mc_ld_done), .mc_rb(mc_rb)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_valid(input string tag, input logic [2:0] exp_fsl);
      chk(tag, {mc_fc_valid, mc_st_valid, mc_ld_valid}, exp_fsl);
   endtask

   initial begin
      step();
      step();
      chk("rst_state", dut.state_q, ARB_IDLE);
      chk_valid("rst_valid", 3'b000);
      chk("rst_done", {fc_done, st_done, ld_done, mc_rb}, 4'b0);
      chk("rst_payload", {mc_addr, mc_st_data}, 64'h0);
      chk("rst_starve", dut.starve_q, 0);
      rst = 1'b0;
      step();
      // store alone
      st_req = 1'b1; st_addr = 32'h100; st_data = 32'hDEADBEEF; st_len = 4'd3;
      step();
      chk_valid("st_grant", 3'b010);
      chk("st_addr", mc_addr, 32'h100);
      chk("st_data", mc_st_data, 32'hDEADBEEF);
      chk("st_len", mc_len, 4'd3);
      mc_fc_done = 1'b1;
      step();
      mc_fc_done = 1'b0;
      chk("st_ignore_fc_done", dut.state_q, ARB_ST);
      chk("st_no_fc_done", fc_done, 1'b0);
      chk("st_payload_stable", mc_addr, 32'h100);
      mc_st_done = 1'b1;
      step();
      mc_st_done = 1'b0; st_req = 1'b0;
      chk("st_done_pulse", st_done, 1'b1);
      chk_valid("st_done_valid", 3'b000);
      chk("st_cool", dut.state_q, ARB_COOL);
      step();
      chk("st_done_one_cycle", st_done, 1'b0);
      chk("st_idle", dut.state_q, ARB_IDLE);
      // all three together: ST, LD, FC
      st_req = 1'b1; st_addr = 32'h110; st_data = 32'h55; st_len = 4'd1;
      ld_req = 1'b1; ld_addr = 32'h300; ld_len = 4'd2; ld_sext = 1'b1; ld_src = 4'd5;
      fc_req = 1'b1; fc_addr = 32'h400;
      step();
      chk_valid("all_first_st", 3'b010);
      chk("all_starve1", dut.starve_q, 1);
      mc_st_done = 1'b1;
      step();
      mc_st_done = 1'b0; st_req = 1'b0;
      chk("all_st_done", st_done, 1'b1);
      step();
      chk_valid("all_gap_idle", 3'b000);
      step();
      chk_valid("all_second_ld", 3'b001);
      chk("all_ld_payload", {mc_addr, mc_len, mc_ld_sext, mc_ld_src}, {32'h300, 4'd2, 1'b1, 4'd5});
      chk("all_starve2", dut.starve_q, 2);
      mc_ld_done = 1'b1;
      step();
      mc_ld_done = 1'b0; ld_req = 1'b0;
      chk("all_ld_done", ld_done, 1'b1);
      step();
      step();
      chk_valid("all_third_fc", 3'b100);
      chk("all_fc_addr", mc_addr, 32'h400);
      chk("all_starve0", dut.starve_q, 0);
      mc_fc_done = 1'b1;
      step();
      mc_fc_done = 1'b0; fc_req = 1'b0;
      chk("all_fc_done", {fc_done, st_done, ld_done}, 3'b100);
      step();
      // starvation: store keeps re-requesting while fetch waits
      fc_req = 1'b1; fc_addr = 32'h500; st_req = 1'b1; st_addr = 32'h600;
      for (int i = 0; i < 2; i++) begin
         step();
         chk_valid("starve_st_grant", 3'b010);
         chk("starve_cnt_inc", dut.starve_q, i + 1);
         mc_st_done = 1'b1;
         step();
         mc_st_done = 1'b0;
         step();
      end
      step();
      chk_valid("starve_fc_wins", 3'b100);
      chk("starve_fc_addr", mc_addr, 32'h500);
      chk("starve_cnt_clear", dut.starve_q, 0);
      mc_fc_done = 1'b1;
      step();
      mc_fc_done = 1'b0; fc_req = 1'b0; st_req = 1'b0;
      chk("starve_fc_done", fc_done, 1'b1);
      step();
      // rb in IDLE blocks the load; then rollback of a granted load
      ld_req = 1'b1; ld_addr = 32'h200; rb = 1'b1;
      step();
      chk("rb_blocks_ld", dut.state_q, ARB_IDLE);
      chk("mc_rb_follow", mc_rb, 1'b1);
      rb = 1'b0; fc_req = 1'b1; fc_addr = 32'h700;
      step();
      chk_valid("rb_ld_grant", 3'b001);
      chk("rb_ld_addr", mc_addr, 32'h200);
      chk("mc_rb_clear", mc_rb, 1'b0);
      step();
      step();
      chk_valid("rb_ld_held", 3'b001);
      rb = 1'b1; mc_ld_done = 1'b1;
      step();
      rb = 1'b0; mc_ld_done = 1'b0; ld_req = 1'b0;
      chk_valid("rb_ld_dropped", 3'b000);
      chk("rb_no_ld_done", ld_done, 1'b0);
      chk("rb_mc_rb", mc_rb, 1'b1);
      chk("rb_cool", dut.state_q, ARB_COOL);
      step();
      chk("rb_no_ld_done_late", ld_done, 1'b0);
      step();
      chk_valid("rb_fc_after_cool", 3'b100);
      chk("rb_fc_addr", mc_addr, 32'h700);
      // async reset mid-FC
      #2;
      rst = 1'b1; mc_fc_done = 1'b1;
      #1;
      chk_valid("arst_valid", 3'b000);
      chk("arst_state", dut.state_q, ARB_IDLE);
      chk("arst_addr", mc_addr, 32'h0);
      chk("arst_no_done", fc_done, 1'b0);
      mc_fc_done = 1'b0; fc_req = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk("arst_no_done_late", {fc_done, dut.state_q}, {1'b0, ARB_IDLE});
      // rdy low freezes
      st_req = 1'b1; st_addr = 32'h800; st_data = 32'h12345678; st_len = 4'd4; rdy = 1'b0;
      step();
      chk("rdy_no_grant", dut.state_q, ARB_IDLE);
      rdy = 1'b1;
      step();
      chk_valid("rdy_st_grant", 3'b010);
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            mc_st_done = 1'b1;
            st_addr = 32'h900;
         end
         step();
         mc_st_done = 1'b0;
         chk_valid("rdy_frozen_valid", 3'b010);
         chk("rdy_frozen_payload", {mc_addr, mc_st_data}, {32'h800, 32'h12345678});
         chk("rdy_no_done", st_done, 1'b0);
      end
      rdy = 1'b1;
      step();
      chk("rdy_resume_st", dut.state_q, ARB_ST);
      mc_st_done = 1'b1;
      step();
      mc_st_done = 1'b0; st_req = 1'b0;
      chk("rdy_st_done", st_done, 1'b1);
      chk_valid("rdy_st_released", 3'b000);
      step();
      chk("rdy_final_idle", {st_done, dut.state_q}, {1'b0, ARB_IDLE});
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
